// File: rtl/mips_mc_controller.sv
// ----------------------------------------------------------------------------
// mips_mc_controller
//
// Multicycle main controller for the MIPS core. A Moore state machine steps
// each instruction through fetch, decode, execute, memory and writeback. It
// stalls on mem_ready in the memory-facing states. It counts FPU latency in
// FPEXEC.
//
// Handshake: in FETCH, MEMRD and MEMWR a memory access is outstanding. It
// completes in the cycle where mem_ready is high, and the FSM advances at
// the following clock edge. While mem_ready is low the state and every
// output hold. mem_ready has no effect in any other state.
//
// op/funct come straight from the instruction register and are not latched
// here. They must stay stable from DECODE until the next FETCH.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset (-> FETCH)
//   op, funct           instruction register fields
//   mem_ready           memory completes current access this cycle
//   pcwrite, branch,    PC update controls (bne inverts the zero test)
//   bne, pcsrc
//   iord, memwrite,     memory address select / write / IR load
//   irwrite
//   regdst, memtoreg,   integer register file writeback controls
//   regwrite
//   fp_regwrite,        FP register file write / FP store data select
//   fp_memsrc
//   alusrca, alusrcb,   ALU operand selects and operation class
//   aluop
//   fpu_start, fpu_op   FPU one-cycle start pulse and operation
//   illegal             one-cycle pulse on an unsupported instruction
//   state               current state encoding (debug)
// ----------------------------------------------------------------------------
module mips_mc_controller #(
    parameter int FP_LAT     = 4,
    parameter int FP_DIV_LAT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       fp_regwrite,
    output logic       fp_memsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       fpu_start,
    output logic [1:0] fpu_op,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int LAT_MAX = (FP_LAT > FP_DIV_LAT) ? FP_LAT : FP_DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LWC1  = 6'b110001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SWC1  = 6'b111001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_FP    = 6'b010001;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_FPEXEC  = 4'd12,
        S_FPWB    = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_lim_m1;
    logic               w_fp_done;
    logic               w_is_load;

    // Divide uses its own latency; add/sub/mul share FP_LAT.
    assign w_lim_m1  = (funct[1:0] == 2'b11) ? CNT_W'(FP_DIV_LAT - 1)
                                             : CNT_W'(FP_LAT - 1);
    assign w_fp_done = (r_cnt == w_lim_m1);
    assign w_is_load = (op == OP_LW) || (op == OP_LWC1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter is zero outside FPEXEC, so it is always zero on FPEXEC entry.
    // That is what makes fpu_start a single pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_FPEXEC && !w_fp_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                         w_next = S_EXEC;
                    OP_LW, OP_LWC1, OP_SW, OP_SWC1:   w_next = S_MEMADR;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_ADDI:                          w_next = S_ADDIEX;
                    OP_J:                             w_next = S_JUMP;
                    OP_FP: w_next = (funct[5:2] == 4'b0000) ? S_FPEXEC : S_ILLEGAL;
                    default:                          w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  w_next = w_is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_FPEXEC:  w_next = w_fp_done ? S_FPWB : S_FPEXEC;
            S_FPWB:    w_next = S_FETCH;
            S_ILLEGAL: w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        branch      = 1'b0;
        bne         = 1'b0;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        fp_regwrite = 1'b0;
        fp_memsrc   = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = 2'b00;
        fpu_start   = 1'b0;
        fpu_op      = 2'b00;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 is written back only when the fetch completes.
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg    = 1'b1;
                regwrite    = (op == OP_LW);
                fp_regwrite = (op == OP_LWC1);
            end
            S_MEMWR: begin
                iord      = 1'b1;
                memwrite  = 1'b1;
                fp_memsrc = (op == OP_SWC1);
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                bne     = op[0];
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_FPEXEC: begin
                fpu_op    = funct[1:0];
                fpu_start = (r_cnt == '0);
            end
            S_FPWB:    fp_regwrite = 1'b1;
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// ----------------------------------------------------------------------------
// tb_mips_mc_controller
//
// Each driven cycle pushes the expected packed output word onto exp_q. A
// negedge monitor pops that word and compares it with the observed outputs.
// The expected words come from a per-state table of the control encoding
// and from an instruction-level sequence of states built by run_instr.
// ----------------------------------------------------------------------------
module tb_mips_mc_controller;

    localparam int FP_LAT     = 4;
    localparam int FP_DIV_LAT = 12;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD = 4'd3,  ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC  = 4'd6,  ST_ALUWB  = 4'd7,  ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_FPEXEC = 4'd12, ST_FPWB  = 4'd13, ST_ILLEGAL = 4'd14;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [5:0] op, funct;
    logic       mem_ready;
    logic       pcwrite, branch, bne, iord, memwrite, irwrite, regdst, memtoreg;
    logic       regwrite, fp_regwrite, fp_memsrc, alusrca, fpu_start, illegal;
    logic [1:0] alusrcb, pcsrc, aluop, fpu_op;
    logic [3:0] state;

    mips_mc_controller #(.FP_LAT(FP_LAT), .FP_DIV_LAT(FP_DIV_LAT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .bne(bne), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .fp_regwrite(fp_regwrite),
        .fp_memsrc(fp_memsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .aluop(aluop), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .illegal(illegal), .state(state)
    );

    // {state, pcwrite, branch, bne, iord, memwrite, irwrite, regdst, memtoreg,
    //  regwrite, fp_regwrite, fp_memsrc, alusrca, alusrcb, pcsrc, aluop,
    //  fpu_start, fpu_op, illegal}
    logic [25:0] w_obs;
    assign w_obs = {state, pcwrite, branch, bne, iord, memwrite, irwrite, regdst,
                    memtoreg, regwrite, fp_regwrite, fp_memsrc, alusrca, alusrcb,
                    pcsrc, aluop, fpu_start, fpu_op, illegal};

    logic [25:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected control word for one cycle spent in state st.
    function automatic logic [25:0] ev(input logic [3:0] st, input logic [5:0] o,
                                       input logic [5:0] f, input logic mr,
                                       input logic first);
        logic pw, br, bn, io, mw, irw, rd, m2r, rw, frw, fms, asa, fs, ill;
        logic [1:0] asb, ps, ao, fo;
        {pw, br, bn, io, mw, irw, rd, m2r, rw, frw, fms, asa, fs, ill} = '0;
        {asb, ps, ao, fo} = '0;
        case (st)
            ST_FETCH:   begin asb = 2'b01; irw = mr; pw = mr; end
            ST_DECODE:  asb = 2'b11;
            ST_MEMADR:  begin asa = 1'b1; asb = 2'b10; end
            ST_MEMRD:   io = 1'b1;
            ST_MEMWB:   begin m2r = 1'b1; rw = (o == 6'b100011); frw = (o == 6'b110001); end
            ST_MEMWR:   begin io = 1'b1; mw = 1'b1; fms = (o == 6'b111001); end
            ST_EXEC:    begin asa = 1'b1; ao = 2'b10; end
            ST_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
            ST_BRANCH:  begin asa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; bn = o[0]; end
            ST_ADDIEX:  begin asa = 1'b1; asb = 2'b10; end
            ST_ADDIWB:  rw = 1'b1;
            ST_JUMP:    begin ps = 2'b10; pw = 1'b1; end
            ST_FPEXEC:  begin fo = f[1:0]; fs = first; end
            ST_FPWB:    frw = 1'b1;
            ST_ILLEGAL: ill = 1'b1;
            default: ;
        endcase
        return {st, pw, br, bn, io, mw, irw, rd, m2r, rw, frw, fms, asa, asb, ps, ao,
                fs, fo, ill};
    endfunction

    // Scoreboard monitor: one expected word per clock, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            logic [25:0] e;
            e = exp_q.pop_front();
            check($sformatf("st%0d_op%b_fn%b", e[25:22], op, funct), 32'(w_obs), 32'(e));
        end
    end

    // Drive one cycle: set mem_ready, record what the DUT must show, advance.
    task automatic cyc(input logic [3:0] st, input logic mr, input logic first);
        mem_ready = mr;
        exp_q.push_back(ev(st, op, funct, mr, first));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fetch_stalls, input int mem_stalls);
        int lat;
        op = o;
        funct = f;
        for (int i = 0; i < fetch_stalls; i++) cyc(ST_FETCH, 1'b0, 1'b0);
        cyc(ST_FETCH, 1'b1, 1'b0);
        cyc(ST_DECODE, 1'($urandom_range(0, 1)), 1'b0);
        case (o)
            6'b000000: begin
                cyc(ST_EXEC, 1'($urandom_range(0, 1)), 1'b0);
                cyc(ST_ALUWB, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b100011, 6'b110001: begin
                cyc(ST_MEMADR, 1'($urandom_range(0, 1)), 1'b0);
                for (int i = 0; i < mem_stalls; i++) cyc(ST_MEMRD, 1'b0, 1'b0);
                cyc(ST_MEMRD, 1'b1, 1'b0);
                cyc(ST_MEMWB, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b101011, 6'b111001: begin
                cyc(ST_MEMADR, 1'($urandom_range(0, 1)), 1'b0);
                for (int i = 0; i < mem_stalls; i++) cyc(ST_MEMWR, 1'b0, 1'b0);
                cyc(ST_MEMWR, 1'b1, 1'b0);
            end
            6'b000100, 6'b000101: cyc(ST_BRANCH, 1'($urandom_range(0, 1)), 1'b0);
            6'b001000: begin
                cyc(ST_ADDIEX, 1'($urandom_range(0, 1)), 1'b0);
                cyc(ST_ADDIWB, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b000010: cyc(ST_JUMP, 1'($urandom_range(0, 1)), 1'b0);
            6'b010001: begin
                if (f[5:2] == 4'b0000) begin
                    lat = (f[1:0] == 2'b11) ? FP_DIV_LAT : FP_LAT;
                    for (int i = 0; i < lat; i++)
                        cyc(ST_FPEXEC, 1'($urandom_range(0, 1)), (i == 0));
                    cyc(ST_FPWB, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    cyc(ST_ILLEGAL, 1'($urandom_range(0, 1)), 1'b0);
                end
            end
            default: cyc(ST_ILLEGAL, 1'($urandom_range(0, 1)), 1'b0);
        endcase
    endtask

    logic [5:0] t_op[12];
    logic [5:0] t_fn[12];

    initial begin
        t_op = '{6'b000000, 6'b100011, 6'b110001, 6'b101011, 6'b111001, 6'b000100,
                 6'b000101, 6'b001000, 6'b000010, 6'b010001, 6'b010001, 6'b111111};
        t_fn = '{6'b100010, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                 6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000001, 6'b000000};

        reset = 1'b1;
        mem_ready = 1'b0;
        op = 6'b0;
        funct = 6'b0;
        #3;
        check("reset_state", 32'(w_obs), 32'(ev(ST_FETCH, op, funct, 1'b0, 1'b0)));
        mem_ready = 1'b1;
        #1;
        check("reset_fetch_mr", 32'(w_obs), 32'(ev(ST_FETCH, op, funct, 1'b1, 1'b0)));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed instructions
        run_instr(6'b000000, 6'b100000, 0, 0);   // ADD: 0,1,6,7
        run_instr(6'b100011, 6'b000000, 0, 3);   // LW, 3 MEMRD stalls
        run_instr(6'b101011, 6'b000000, 1, 2);   // SW, fetch + memwr stalls
        run_instr(6'b111001, 6'b000000, 0, 1);   // SWC1
        run_instr(6'b110001, 6'b000000, 0, 0);   // LWC1
        run_instr(6'b000100, 6'b000000, 0, 0);   // BEQ
        run_instr(6'b000101, 6'b000000, 0, 0);   // BNE
        run_instr(6'b001000, 6'b000000, 0, 0);   // ADDI
        run_instr(6'b000010, 6'b000000, 0, 0);   // J
        run_instr(6'b010001, 6'b000000, 0, 0);   // FP add, L=FP_LAT
        run_instr(6'b010001, 6'b000011, 0, 0);   // FP div, L=FP_DIV_LAT
        run_instr(6'b010001, 6'b000010, 0, 0);   // FP mul
        run_instr(6'b111111, 6'b000000, 0, 0);   // illegal opcode
        run_instr(6'b010001, 6'b000100, 0, 0);   // illegal FP funct

        // Async reset in the middle of an FP divide, at cnt=5
        op = 6'b010001;
        funct = 6'b000011;
        cyc(ST_FETCH, 1'b1, 1'b0);
        cyc(ST_DECODE, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(ST_FPEXEC, 1'b1, (i == 0));
        mem_ready = 1'b1;
        exp_q.push_back(ev(ST_FPEXEC, op, funct, 1'b1, 1'b0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_fpexec", 32'(w_obs), 32'(ev(ST_FETCH, op, funct, 1'b1, 1'b0)));
        @(posedge clk);
        #1;
        check("rst_held", 32'(w_obs), 32'(ev(ST_FETCH, op, funct, 1'b1, 1'b0)));
        reset = 1'b0;
        // A fresh divide must run the full latency with one start pulse.
        run_instr(6'b010001, 6'b000011, 0, 0);

        // Async reset while a store is stalled in MEMWR
        op = 6'b101011;
        funct = 6'b000000;
        cyc(ST_FETCH, 1'b1, 1'b0);
        cyc(ST_DECODE, 1'b1, 1'b0);
        cyc(ST_MEMADR, 1'b1, 1'b0);
        mem_ready = 1'b0;
        exp_q.push_back(ev(ST_MEMWR, op, funct, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_memwr", 32'(w_obs), 32'(ev(ST_FETCH, op, funct, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random mix with random stalls
        for (int n = 0; n < 30; n++) begin
            int k;
            k = $urandom_range(0, 11);
            run_instr(t_op[k], t_fn[k], $urandom_range(0, 2), $urandom_range(0, 2));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle main controller for the MIPS core. It replaces the single-cycle combinational main decoder with a Moore-style state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It stalls on a memory-ready handshake and runs a parametrised latency counter for multi-cycle FPU operations. It sits between the instruction register (op, funct) and the multicycle datapath and FPU.

## Interface

Parameters:
- FP_LAT, 4: cycles an FPU add/sub/mul occupies in FPEXEC (≥1)
- FP_DIV_LAT, 12: cycles an FPU divide occupies in FPEXEC (≥1)
- CNT_W, $clog2(max(FP_LAT,FP_DIV_LAT)+1): latency counter width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  6  opcode from instruction register
- funct  in  6  function field from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- pcwrite  out  1  unconditional PC write
- branch  out  1  conditional PC write
- bne  out  1  invert zero test (1 for BNE)
- iord  out  1  memory address from ALUOut (1) or PC (0)
- memwrite  out  1  memory write request
- irwrite  out  1  load instruction register
- regdst  out  1  rd (1) / rt (0) destination
- memtoreg  out  1  writeback from data register
- regwrite  out  1  integer register file write
- fp_regwrite  out  1  FP register file write
- fp_memsrc  out  1  store data from FP file (SWC1)
- alusrca  out  1  ALU A = register (1) / PC (0)
- alusrcb  out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  2  00 add, 01 sub, 10 by funct
- fpu_start  out  1  one-cycle start pulse to FPU
- fpu_op  out  2  funct[1:0]: 00 add, 01 sub, 10 mul, 11 div
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  4  current state encoding (debug)

## Operation

- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, FPEXEC 12, FPWB 13, ILLEGAL 14.
- Default for all outputs is 0 in every state; only the signals listed per state are asserted.
- FETCH: alusrcb=01, aluop=00, pcsrc=00, iord=0. irwrite=pcwrite=mem_ready. Goes to DECODE on mem_ready, else stays.
- DECODE: alusrcb=11. Next state by op:
  - 000000 → EXEC
  - 100011/110001 (LW/LWC1) or 101011/111001 (SW/SWC1) → MEMADR
  - 000100/000101 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 010001 → FPEXEC if funct[5:2]==0000, else ILLEGAL
  - other → ILLEGAL
- MEMADR: alusrca=1, alusrcb=10. Loads go to MEMRD, stores to MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: memtoreg=1, regdst=0. regwrite=1 for LW, fp_regwrite=1 for LWC1. Then FETCH.
- MEMWR: iord=1, memwrite=1, fp_memsrc=(op==111001). Held until mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Then ALUWB: regdst=1, regwrite=1. Then FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, bne=op[0]. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Then ADDIWB: regwrite=1, regdst=0. Then FETCH.
- JUMP: pcsrc=10, pcwrite=1. Then FETCH.
- FPEXEC:
  - fpu_op=funct[1:0] throughout.
  - fpu_start=1 only in the first cycle, when cnt==0.
  - cnt increments each cycle. Limit L=FP_DIV_LAT if funct[1:0]==11, else FP_LAT.
  - When cnt==L-1, cnt clears and the state goes to FPWB.
- FPWB: fp_regwrite=1. Then FETCH.
- ILLEGAL: illegal=1. Then FETCH. No register or memory write occurs.

## Timing

- Reset (asynchronous, any state including mid-FPEXEC or a stalled MEMWR): state=FETCH, cnt=0 immediately. Outputs take FETCH values: alusrcb=01, all else 0 except irwrite/pcwrite, which follow mem_ready. No fpu_start is issued until a new FPEXEC entry.
- Cycles per instruction, with zero memory wait:
  - R-type 4, ADDI 4, BEQ/BNE 3, J 3
  - LW 5, SW 4
  - FP op 2+L+1
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one stall cycle. Outputs stay constant during the stall.
- mem_ready is ignored in all other states.
- cnt never exceeds L-1. With L=1, FPEXEC lasts one cycle, with fpu_start=1 in that cycle.
- op/funct must be stable from DECODE to FETCH. The controller does not latch them.

## Test plan

- Reset asserted during FPEXEC of a divide (cnt=5) → state=0 and cnt=0 in the same cycle. After release with mem_ready=1, irwrite=pcwrite=1 in the first cycle.
- ADD (op 000000, funct 100000), mem_ready=1 → state sequence 0,1,6,7,0. aluop=10 in EXEC, regdst=regwrite=1 in ALUWB.
- LW with mem_ready low for 3 cycles in MEMRD → 3 extra MEMRD cycles with iord=1. Then MEMWB with memtoreg=regwrite=1; total 8 cycles.
- FP divide (op 010001, funct 000011) with FP_DIV_LAT=12 → fpu_start high exactly 1 cycle, fpu_op=11, 12 cycles in FPEXEC, then fp_regwrite=1 for 1 cycle.
- BNE (op 000101) → BRANCH with branch=1, bne=1, pcsrc=01, aluop=01. Back in FETCH after 3 cycles.
- op 111111 and op 010001/funct 000100 → illegal pulses 1 cycle, regwrite=memwrite=fp_regwrite=0 throughout, return to FETCH.
